// File: rtl/dot_matrix_keypad_if.sv
// Button-side inputs and move-pulse outputs of the keypad conditioner.
// No latency of its own; it only carries signals.
// No backpressure; the pulses are fire-and-forget.
interface dot_matrix_keypad_if;
  logic       power;
  logic [3:0] btn_raw;   // {left, down, right, up}, 1 = pressed
  logic       up;
  logic       down;
  logic       right;
  logic       left;
  logic       key_held;
  logic       lockout;

  // The master drives the buttons and power and watches the moves.
  modport master (
    output power, btn_raw,
    input  up, down, right, left, key_held, lockout
  );

  // The slave is the keypad conditioner itself.
  modport slave (
    input  power, btn_raw,
    output up, down, right, left, key_held, lockout
  );
endinterface

// File: rtl/dot_matrix_keypad.sv
// Synchronises, debounces and arbitrates four direction buttons into one-hot move pulses.
// First pulse is high in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES+1 of a held press.
// No backpressure: the cursor stage must take every one-cycle pulse as it comes.
module dot_matrix_keypad #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 8,
  parameter bit REPEAT_EN       = 1'b1
) (
  input logic           clk,
  input logic           reset,   // asynchronous, active low
  dot_matrix_keypad_if.slave kp
);

  localparam int DCW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HCW    = $clog2(HC_MAX + 1);

  localparam logic [DCW-1:0] DB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCW-1:0] RD_LAST  = HCW'(REPEAT_DELAY - 1);
  localparam logic [HCW-1:0] RR_LAST  = HCW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  sync;
  logic [3:0][DCW-1:0]         cnt_q, cnt_d;
  logic [3:0]                  db_q, db_d;
  state_t                      state_q, state_d;
  logic [3:0]                  key_q, key_d;
  logic [HCW-1:0]              hc_q, hc_d;
  logic [HCW-1:0]              hc_inc;
  logic [HCW-1:0]              rep_last;
  logic [3:0]                  pulse_q, pulse_d;
  logic                        db_onehot;

  assign sync = sync_q[SYNC_STAGES-1];

  // Shift each raw button through its own synchroniser chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], kp.btn_raw};
    end
  end

  // Per-bit debounce: accept a level only after it has differed for DEBOUNCE_CYCLES edges.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    for (int i = 0; i < 4; i++) begin
      if (sync[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= DB_LAST) begin
        db_d[i]  = sync[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DCW'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      db_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db_onehot = (db_q != 4'd0) && ((db_q & (db_q - 4'd1)) == 4'd0);
  assign hc_inc    = (&hc_q) ? hc_q : hc_q + HCW'(1);
  assign rep_last  = (state_q == ST_PRESSED) ? RD_LAST : RR_LAST;

  // Arbitration FSM: a release always beats a due repeat, and any second key locks out.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    hc_d    = hc_q;
    pulse_d = 4'd0;
    if (!kp.power) begin
      state_d = ST_IDLE;
      hc_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (db_onehot) begin
            key_d   = db_q;
            pulse_d = db_q;
            hc_d    = '0;
            state_d = ST_PRESSED;
          end else if (db_q != 4'd0) begin
            state_d = ST_LOCKOUT;
          end
        end
        ST_PRESSED, ST_REPEAT: begin
          if (db_q == 4'd0) begin
            state_d = ST_IDLE;
          end else if (db_q != key_q) begin
            state_d = ST_LOCKOUT;
          end else if (REPEAT_EN && (hc_q == rep_last)) begin
            pulse_d = key_q;
            hc_d    = '0;
            state_d = ST_REPEAT;
          end else begin
            hc_d = hc_inc;
          end
        end
        ST_LOCKOUT: begin
          if (db_q == 4'd0) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM, latched key, hold counter and registered pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      key_q   <= 4'd0;
      hc_q    <= '0;
      pulse_q <= 4'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      hc_q    <= hc_d;
      pulse_q <= pulse_d;
    end
  end

  assign kp.up       = pulse_q[0];
  assign kp.right    = pulse_q[1];
  assign kp.down     = pulse_q[2];
  assign kp.left     = pulse_q[3];
  assign kp.key_held = (state_q == ST_PRESSED) || (state_q == ST_REPEAT);
  assign kp.lockout  = (state_q == ST_LOCKOUT);

endmodule
